// File: rtl/counter_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_driver_if
// Purpose  : Control/status bus between counter_driver and the up/down counter.
// Revision : 1.0
// ============================================================================
interface counter_driver_if;
    logic       load_en;
    logic [3:0] count_to;
    logic       count_inc;
    logic       count_dec;
    logic       flag_max;
    logic       flag_min;

    modport master (
        output load_en, count_to, count_inc, count_dec,
        input  flag_max, flag_min
    );

    modport slave (
        input  load_en, count_to, count_inc, count_dec,
        output flag_max, flag_min
    );
endinterface
`default_nettype wire

// File: rtl/counter_driver.sv
`default_nettype none
// ============================================================================
// Module   : counter_driver
// Purpose  : Sequencer that loads a limit into the counter, then issues
//            inc/dec pulses while tracking flag hits, abort and completion.
// Revision : 1.0
// ============================================================================
module counter_driver #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir,
    input  logic [3:0]        limit,
    input  logic [STEP_W-1:0] steps,
    input  logic              stop_on_flag,
    input  logic              abort,
    counter_driver_if.master  cnt,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              hit_max,
    output logic              hit_min,
    output logic [STEP_W-1:0] issued
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_GAP  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_dir;
    logic              r_stop_on_flag;
    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] r_issued;
    logic [3:0]        r_count_to;
    logic              r_aborted;
    logic              r_hit_max;
    logic              r_hit_min;
    logic              w_accept;
    logic              w_active;
    logic              w_flag_stop;

    // Abort beats start in IDLE, so a combined strobe never launches a sequence.
    assign w_accept    = (r_state == c_IDLE) && start && !abort;
    assign w_active    = (r_state == c_LOAD) || (r_state == c_RUN) || (r_state == c_GAP);
    assign w_flag_stop = r_stop_on_flag &&
                         (r_hit_max || r_hit_min || cnt.flag_max || cnt.flag_min);

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        cnt.load_en   = 1'b0;
        cnt.count_inc = 1'b0;
        cnt.count_dec = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next_state = c_LOAD;
                end
            end
            c_LOAD: begin
                cnt.load_en = 1'b1;
                if (abort || (r_steps == '0)) begin
                    w_next_state = c_DONE;
                end else begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                cnt.count_inc = r_dir;
                cnt.count_dec = !r_dir;
                w_next_state  = abort ? c_DONE : c_GAP;
            end
            c_GAP: begin
                if (abort || (r_issued == r_steps) || w_flag_stop) begin
                    w_next_state = c_DONE;
                end else begin
                    w_next_state = c_RUN;
                end
            end
            c_DONE: begin
                done         = 1'b1;
                w_next_state = c_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_dir          <= 1'b0;
            r_stop_on_flag <= 1'b0;
            r_steps        <= '0;
            r_issued       <= '0;
            r_count_to     <= 4'd0;
            r_aborted      <= 1'b0;
            r_hit_max      <= 1'b0;
            r_hit_min      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dir          <= dir;
                r_stop_on_flag <= stop_on_flag;
                r_steps        <= steps;
                r_count_to     <= limit;
                r_issued       <= '0;
                r_aborted      <= 1'b0;
                r_hit_max      <= 1'b0;
                r_hit_min      <= 1'b0;
            end
            // A pulse driven in the abort cycle still counts.
            if (r_state == c_RUN) begin
                r_issued <= r_issued + 1'b1;
            end
            if (w_active) begin
                if (cnt.flag_max) r_hit_max <= 1'b1;
                if (cnt.flag_min) r_hit_min <= 1'b1;
                if (abort)        r_aborted <= 1'b1;
            end
        end
    end

    assign cnt.count_to = r_count_to;
    assign aborted      = r_aborted;
    assign hit_max      = r_hit_max;
    assign hit_min      = r_hit_min;
    assign issued       = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_counter_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_driver
// Purpose  : Scoreboard bench for counter_driver strobe timing and status.
// Revision : 1.0
// ============================================================================
module tb_counter_driver;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       dir;
    logic [3:0] limit;
    logic [7:0] steps;
    logic       stop_on_flag;
    logic       abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       hit_max;
    logic       hit_min;
    logic [7:0] issued;

    counter_driver_if cif ();

    counter_driver #(.STEP_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .dir          (dir),
        .limit        (limit),
        .steps        (steps),
        .stop_on_flag (stop_on_flag),
        .abort        (abort),
        .cnt          (cif),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .hit_max      (hit_max),
        .hit_min      (hit_min),
        .issued       (issued)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle strobes {load_en, count_inc, count_dec, done, busy}
    logic [4:0]  exp_q[$];
    // Status at done {issued, hit_max, hit_min, aborted}
    logic [10:0] st_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected model: done in cycle dc, load in cycle 1, pulses on even cycles before dc.
    task automatic push_expect(input logic d, input int dc, input logic [7:0] iss,
                               input logic hmx, input logic hmn, input logic ab);
        logic [4:0] e;
        logic       p;
        for (int c = 1; c <= dc + 1; c++) begin
            p    = (c >= 2) && (c < dc) && (c % 2 == 0);
            e[4] = (c == 1);
            e[3] = p && d;
            e[2] = p && !d;
            e[1] = (c == dc);
            e[0] = (c <= dc);
            exp_q.push_back(e);
        end
        st_q.push_back({iss, hmx, hmn, ab});
    endtask

    task automatic launch(input logic d, input logic [3:0] lim, input logic [7:0] n,
                          input logic sof);
        dir = d; limit = lim; steps = n; stop_on_flag = sof; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({cif.load_en, cif.count_inc, cif.count_dec, cif.count_to, busy, done,
             aborted, hit_max, hit_min, issued} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_held: outputs %b, want all zero",
                     {cif.load_en, cif.count_inc, cif.count_dec, cif.count_to, busy, done,
                      aborted, hit_max, hit_min, issued});
        end
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if ({cif.load_en, cif.count_inc, cif.count_dec, cif.count_to, busy, done,
             aborted, hit_max, hit_min, issued} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_released: outputs %b, want all zero",
                     {cif.load_en, cif.count_inc, cif.count_dec, cif.count_to, busy, done,
                      aborted, hit_max, hit_min, issued});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_up();
        logic [4:0]  e, got;
        logic [10:0] s;
        push_expect(1'b1, 8, 8'd3, 1'b0, 1'b0, 1'b0);
        launch(1'b1, 4'd5, 8'd3, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            got = {cif.load_en, cif.count_inc, cif.count_dec, done, busy};
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL up_strobes c%0d: got %b want %b", c, got, e);
            end
            if (c == 1) begin
                n_vec++;
                if (cif.count_to !== 4'd5) begin
                    n_err++; $display("FAIL up_count_to: got %0d want 5", cif.count_to);
                end
            end
            if (done && st_q.size() != 0) begin
                s = st_q.pop_front();
                n_vec++;
                if ({issued, hit_max, hit_min, aborted} !== s) begin
                    n_err++; $display("FAIL up_status: got %h want %h",
                                      {issued, hit_max, hit_min, aborted}, s);
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (st_q.size() != 0) begin
            n_err++; $display("FAIL up_done_missing: %0d pending, want 0", st_q.size());
            st_q.delete();
        end
    endtask

    task automatic test_zero_steps();
        logic [4:0]  e, got;
        logic [10:0] s;
        push_expect(1'b0, 2, 8'd0, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 4'd3, 8'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            got = {cif.load_en, cif.count_inc, cif.count_dec, done, busy};
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL zero_strobes c%0d: got %b want %b", c, got, e);
            end
            if (c == 1) begin
                n_vec++;
                if (cif.count_to !== 4'd3) begin
                    n_err++; $display("FAIL zero_count_to: got %0d want 3", cif.count_to);
                end
            end
            if (done && st_q.size() != 0) begin
                s = st_q.pop_front();
                n_vec++;
                if ({issued, hit_max, hit_min, aborted} !== s) begin
                    n_err++; $display("FAIL zero_status: got %h want %h",
                                      {issued, hit_max, hit_min, aborted}, s);
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (st_q.size() != 0) begin
            n_err++; $display("FAIL zero_done_missing: %0d pending, want 0", st_q.size());
            st_q.delete();
        end
    endtask

    // Flag in RUN cycle 6: stops at done cycle 8 with stop_on_flag, else runs to 22.
    task automatic test_flag_stop();
        logic [4:0]  e, got;
        logic [10:0] s;
        for (int run = 0; run < 2; run++) begin
            push_expect(1'b1, (run == 0) ? 8 : 22, (run == 0) ? 8'd3 : 8'd10,
                        1'b1, 1'b0, 1'b0);
            launch(1'b1, 4'd9, 8'd10, (run == 0));
            for (int c = 1; c <= ((run == 0) ? 9 : 23); c++) begin
                cif.flag_max = (c == 6);
                @(negedge clk);
                got = {cif.load_en, cif.count_inc, cif.count_dec, done, busy};
                e = exp_q.pop_front();
                n_vec++;
                if (got !== e) begin
                    n_err++; $display("FAIL flag%0d_strobes c%0d: got %b want %b",
                                      run, c, got, e);
                end
                if (done && st_q.size() != 0) begin
                    s = st_q.pop_front();
                    n_vec++;
                    if ({issued, hit_max, hit_min, aborted} !== s) begin
                        n_err++; $display("FAIL flag%0d_status: got %h want %h", run,
                                          {issued, hit_max, hit_min, aborted}, s);
                    end
                end
                @(posedge clk); #1;
            end
            cif.flag_max = 1'b0;
            n_vec++;
            if (st_q.size() != 0) begin
                n_err++; $display("FAIL flag%0d_done_missing: %0d pending, want 0",
                                  run, st_q.size());
                st_q.delete();
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0]  e, got;
        logic [10:0] s;
        push_expect(1'b1, 5, 8'd2, 1'b0, 1'b0, 1'b1);
        launch(1'b1, 4'd2, 8'd5, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            abort = (c == 4);
            start = (c == 3);
            @(negedge clk);
            got = {cif.load_en, cif.count_inc, cif.count_dec, done, busy};
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL abort_strobes c%0d: got %b want %b", c, got, e);
            end
            if (done && st_q.size() != 0) begin
                s = st_q.pop_front();
                n_vec++;
                if ({issued, hit_max, hit_min, aborted} !== s) begin
                    n_err++; $display("FAIL abort_status: got %h want %h",
                                      {issued, hit_max, hit_min, aborted}, s);
                end
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (st_q.size() != 0) begin
            n_err++; $display("FAIL abort_done_missing: %0d pending, want 0", st_q.size());
            st_q.delete();
        end
        // start with abort in IDLE must not launch and must leave sticky bits alone
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({busy, cif.load_en, aborted, issued} !== {1'b0, 1'b0, 1'b1, 8'd2}) begin
                n_err++; $display("FAIL start_abort_idle c%0d: busy/load/aborted/issued %b, want 0/0/1/2",
                                  c, {busy, cif.load_en, aborted, issued});
            end
            @(posedge clk); #1;
        end
    endtask

    // Second start lands in the IDLE cycle right after done.
    task automatic test_back_to_back();
        logic [4:0]  e, got;
        logic [10:0] s;
        push_expect(1'b0, 6, 8'd2, 1'b0, 1'b1, 1'b0);
        push_expect(1'b1, 4, 8'd1, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 4'd4, 8'd2, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            cif.flag_min = (c == 2);
            if (c == 7) begin
                dir = 1'b1; limit = 4'd7; steps = 8'd1; stop_on_flag = 1'b0;
            end
            start = (c == 7);
            @(negedge clk);
            got = {cif.load_en, cif.count_inc, cif.count_dec, done, busy};
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_err++; $display("FAIL b2b_strobes c%0d: got %b want %b", c, got, e);
            end
            if (c == 8) begin
                n_vec++;
                if ({hit_min, issued, cif.count_to} !== {1'b0, 8'd0, 4'd7}) begin
                    n_err++; $display("FAIL b2b_cleared: hit_min/issued/count_to %b, want 0/0/7",
                                      {hit_min, issued, cif.count_to});
                end
            end
            if (done && st_q.size() != 0) begin
                s = st_q.pop_front();
                n_vec++;
                if ({issued, hit_max, hit_min, aborted} !== s) begin
                    n_err++; $display("FAIL b2b_status c%0d: got %h want %h", c,
                                      {issued, hit_max, hit_min, aborted}, s);
                end
            end
            @(posedge clk); #1;
        end
        cif.flag_min = 1'b0;
        n_vec++;
        if (st_q.size() != 0) begin
            n_err++; $display("FAIL b2b_done_missing: %0d pending, want 0", st_q.size());
            st_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        launch(1'b1, 4'd1, 8'd4, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_vec++;
        if ({cif.count_inc, issued} !== {1'b1, 8'd1}) begin
            n_err++; $display("FAIL mid_run_pre: inc/issued %b, want 1/1", {cif.count_inc, issued});
        end
        #1 reset_n = 1'b1;
        #1;
        n_vec++;
        if ({cif.count_inc, busy, issued, cif.count_to} !== 14'd0) begin
            n_err++; $display("FAIL mid_run_reset: inc/busy/issued/count_to %b, want 0",
                              {cif.count_inc, busy, issued, cif.count_to});
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; dir = 1'b0; limit = 4'd0; steps = 8'd0;
        stop_on_flag = 1'b0; abort = 1'b0;
        cif.flag_max = 1'b0; cif.flag_min = 1'b0;
        test_reset();
        test_up();
        test_zero_steps();
        test_flag_stop();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_driver.md
# counter_driver

Command sequencer that drives the up/down counter's control interface. It accepts a host request (direction, limit, step count), loads the limit through `load_en`/`count_to`, then issues single-cycle `count_inc` or `count_dec` pulses while monitoring `flag_max`/`flag_min`. It reports completion, abort and flag-hit status back to the host. It sits between the host/test controller and the counter block.

## Interface
- STEP_W, 8, width of step count and issued-pulse counter
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-high
- start  in  1  request strobe; accepted only in IDLE
- dir  in  1  1 = count up (inc), 0 = count down (dec); captured on accepted start
- limit  in  4  value sent on count_to; captured on accepted start
- steps  in  STEP_W  number of pulses to issue; captured on accepted start
- stop_on_flag  in  1  1 = end the sequence at the first flag hit; captured on accepted start
- abort  in  1  terminate the current sequence
- flag_max  in  1  from counter
- flag_min  in  1  from counter
- load_en  out  1  to counter, one-cycle load strobe
- count_to  out  4  to counter; registered, holds the last captured limit
- count_inc  out  1  to counter
- count_dec  out  1  to counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  sticky; set when a sequence ends by abort
- hit_max  out  1  sticky; flag_max seen during the sequence
- hit_min  out  1  sticky; flag_min seen during the sequence
- issued  out  STEP_W  number of inc/dec pulses issued in the current or last sequence

## Operation
- Reset value of every output is 0: count_to=0, issued=0, all flags and strobes 0. The state machine resets to IDLE.
- States and transitions:
  - IDLE: waits. On start=1 and abort=0, it captures dir, limit, steps and stop_on_flag; clears issued, hit_max, hit_min and aborted; goes to LOAD. Otherwise stays in IDLE.
  - LOAD: load_en=1 and count_to=limit for exactly one cycle. If steps==0, go to DONE; else go to RUN.
  - RUN: drives one pulse for one cycle (count_inc=dir, count_dec=~dir); increments issued; goes to GAP.
  - GAP: count_inc=count_dec=0. Next state is DONE if either of these holds: issued==steps, or stop_on_flag=1 and a flag was seen. Otherwise go to RUN.
  - DONE: done=1 for one cycle; goes to IDLE.
- Outputs are registered: all strobes are decoded from the registered state.
- count_inc and count_dec are never high in the same cycle, and are never high outside RUN.
- load_en is never high outside LOAD.
- Flag sampling:
  - flag_max and flag_min are sampled every cycle in LOAD, RUN and GAP.
  - Any sample of 1 sets hit_max or hit_min respectively.
  - The sticky bits hold through IDLE until the next accepted start.
- Abort:
  - abort=1 in LOAD, RUN or GAP sends the state to DONE on the next edge and sets aborted.
  - A pulse already driven in the abort cycle still counts in issued.
  - abort in DONE or IDLE is ignored.
- Simultaneous events:
  - start while busy is ignored (not queued).
  - start and abort together in IDLE: abort wins, and start is not accepted.
  - A flag hit and the last step in the same GAP go to DONE once; the hit bit is set.
- issued width is STEP_W. steps = 2^STEP_W−1 is legal, so no wrap occurs.
- Reset mid-sequence: all outputs drop to 0 asynchronously. No partial pulse is extended.

## Timing
- Latency from accepted start (edge 0), for N = steps:
  - load_en is high in cycle 1.
  - The first pulse is in cycle 2.
  - Pulses occur in cycles 2, 4, …, 2N.
  - done is high in cycle 2N+2 (N=0 gives done in cycle 2).
- busy rises in cycle 1, falls in the cycle after done, and spans cycles 1 through 2N+2.
- A new start is accepted in the first cycle after done (back-to-back throughput: one sequence every 2N+3 cycles).
- Abort seen at edge k (state LOAD/RUN/GAP): done in cycle k+1, busy low in cycle k+2.
- With stop_on_flag, a flag arriving in RUN cycle 2j ends the sequence: done in cycle 2j+2, issued=j.

## Test plan
- Reset held, then released: all outputs 0, busy=0. Assert reset during RUN: count_inc drops immediately and issued=0.
- start with dir=1, limit=5, steps=3: load_en high in cycle 1 with count_to=5; count_inc in cycles 2/4/6; done in cycle 8; issued=3; count_dec never high.
- start with dir=0, steps=0: load_en in cycle 1, done in cycle 2, no pulses, issued=0.
- dir=1, steps=10, stop_on_flag=1, flag_max driven high in cycle 6: hit_max=1, done in cycle 8, issued=3. Repeat with stop_on_flag=0: done in cycle 22, issued=10, hit_max stays 1.
- abort in cycle 4 of a steps=5 run: aborted=1, done in cycle 5, issued=2. A start asserted during busy is ignored; start and abort together in IDLE give busy=0.
- Back-to-back: second start in the cycle after done is accepted. Sticky bits from the first run are cleared in the cycle after the second start.
